// File: rtl/isqrt_pipe_with_valid.sv
// Pipelined integer square root, floor(sqrt(x)), one restoring stage per result bit.
// Latency: width/2 cycles from the x_vld edge to y_vld; one operand accepted per cycle.
// Backpressure: none; the valid chain carries bubbles and the output cannot stall.
module isqrt_pipe_with_valid #(
    parameter int width = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x_vld,
    input  logic [width-1:0]   x,
    output logic               y_vld,
    output logic [width/2-1:0] y
);

    localparam int H  = width / 2;
    localparam int RW = H + 2;

    genvar k;
    generate
        for (k = 0; k < H; k++) begin : g_stage
            logic             vld_q;
            logic [RW-1:0]    rem_q;
            logic [H-1:0]     root_q;
            logic [width-1:0] rad_q;

            logic             in_vld;
            logic [RW-1:0]    in_rem;
            logic [H-1:0]     in_root;
            logic [width-1:0] in_rad;

            logic [RW-1:0]    shifted;
            logic [RW-1:0]    sub;
            logic [RW-1:0]    trial;
            logic             ge;
            logic             unused_in;

            if (k == 0) begin : g_head
                assign in_vld  = x_vld;
                assign in_rem  = '0;
                assign in_root = '0;
                assign in_rad  = x;
            end else begin : g_body
                assign in_vld  = g_stage[k-1].vld_q;
                assign in_rem  = g_stage[k-1].rem_q;
                assign in_root = g_stage[k-1].root_q;
                assign in_rad  = g_stage[k-1].rad_q;
            end

            // Before the last stage the remainder stays below 2^H, so dropping its
            // top two bits on the shift is exact and the datapath never needs RW+1 bits.
            assign shifted = {in_rem[H-1:0], in_rad[width-1 -: 2]};
            assign sub     = {in_root, 2'b01};
            assign ge      = (shifted >= sub);
            assign trial   = shifted - sub;
            assign unused_in = ^{in_rem[RW-1:H], in_root[H-1]};

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld_q  <= 1'b0;
                    rem_q  <= '0;
                    root_q <= '0;
                    rad_q  <= '0;
                end else begin
                    vld_q <= in_vld;
                    if (in_vld) begin
                        rem_q  <= ge ? trial : shifted;
                        root_q <= {in_root[H-2:0], ge};
                        rad_q  <= {in_rad[width-3:0], 2'b00};
                    end
                end
            end

            if (k == H - 1) begin : g_tail
                logic unused_tail;
                assign unused_tail = ^{rem_q, rad_q};
            end
        end
    endgenerate

    assign y_vld = g_stage[H-1].vld_q;
    assign y     = g_stage[H-1].root_q;

endmodule
